// File: rtl/status_leds_pwm_multi.sv
// rtl/status_leds_pwm_multi.sv - multi-channel status LED PWM driver with level and activity/fade modes
// Shared prescaler/PWM/decay timebase; per-channel envelope, period-latched duty and registered compare.

module status_leds_pwm_multi #(
   parameter int CHANNELS    = 4,
   parameter int BRIGHT_BITS = 6,
   parameter int PRESCALE    = 256,
   parameter int DECAY_DIV   = 4
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [CHANNELS*BRIGHT_BITS-1:0] level,
   input  logic [CHANNELS-1:0]             activity,
   input  logic [CHANNELS-1:0]             mode,
   output logic [CHANNELS-1:0]             leds_out,
   output logic                            pwm_sync
);

   localparam int PS_W = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
   localparam int DD_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [PS_W-1:0]        PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [DD_W-1:0]        DD_LAST = DD_W'(DECAY_DIV - 1);
   localparam logic [BRIGHT_BITS-1:0] B_ONES  = '1;

   logic [PS_W-1:0]        r_presc;
   logic [BRIGHT_BITS-1:0] r_pwm_cnt;
   logic [DD_W-1:0]        r_decay;
   logic                   w_step;
   logic                   w_period_start;
   logic                   w_decay_tick;
   logic [CHANNELS-1:0]    w_led_nxt;

   assign w_step         = (r_presc == PS_LAST);
   assign w_period_start = w_step && (r_pwm_cnt == B_ONES);
   assign w_decay_tick   = w_period_start && (r_decay == DD_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_presc <= '0;
      end else if (w_step) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pwm_cnt <= '0;
      end else if (w_step) begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_decay <= '0;
      end else if (w_period_start) begin
         if (w_decay_tick) begin
            r_decay <= '0;
         end else begin
            r_decay <= r_decay + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pwm_sync <= 1'b0;
      end else begin
         pwm_sync <= w_period_start;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [BRIGHT_BITS-1:0] r_env;
      logic [BRIGHT_BITS-1:0] r_duty;

      // Activity overrides a coincident decay step; duty latches the pre-decrement envelope.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            r_env <= '0;
         end else if (activity[i]) begin
            r_env <= B_ONES;
         end else if (w_decay_tick && (r_env != '0)) begin
            r_env <= r_env - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            r_duty <= '0;
         end else if (w_period_start) begin
            r_duty <= mode[i] ? r_env : level[i*BRIGHT_BITS +: BRIGHT_BITS];
         end
      end

      assign w_led_nxt[i] = (r_duty == B_ONES) || (r_pwm_cnt < r_duty);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         leds_out <= '0;
      end else begin
         leds_out <= w_led_nxt;
      end
   end

endmodule
